// File: rtl/rd73_weight_enum_if.sv
// Request / output stream bundle for the rd73 weight enumerator.
interface rd73_weight_enum_if #(
    parameter int unsigned N     = 7,
    parameter int unsigned WW    = 3,
    parameter int unsigned IDX_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [WW-1:0]    req_weight;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_word;
    logic             out_last;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] out_total;
    logic             busy;
    logic             err;

    // Requester / sink side
    modport master (
        output req_valid, req_weight, out_ready,
        input  req_ready, out_valid, out_word, out_last, out_index, out_total, busy, err
    );

    // Enumerator side
    modport slave (
        input  req_valid, req_weight, out_ready,
        output req_ready, out_valid, out_word, out_last, out_index, out_total, busy, err
    );
endinterface

// File: rtl/rd73_weight_enum.sv
// Streams every N-bit word of popcount k in ascending order (inverse of rd73).
module rd73_weight_enum #(
    parameter int unsigned N     = 7,
    parameter int unsigned WW    = 3,
    parameter int unsigned IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    rd73_weight_enum_if.slave   bus
);
    localparam int unsigned NP1  = N + 1;
    localparam int unsigned CW   = $clog2(N + 2);
    localparam int unsigned NTAB = 1 << WW;

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_EMIT = 1'b1;
    localparam logic [WW-1:0] N_W     = WW'(N);

    // Binomial coefficient, evaluated only at elaboration
    function automatic int unsigned f_binom(input int unsigned n, input int unsigned k);
        int unsigned c;
        c = 1;
        if (k > n) return 0;
        for (int unsigned i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    logic [0:0]       r_state;
    logic [N-1:0]     r_word;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_total;
    logic             r_last;
    logic             r_err;
    logic             r_req_ready;
    logic             r_busy;

    logic [0:0]       w_state_nxt;
    logic [N-1:0]     w_word_nxt;
    logic [IDX_W-1:0] w_index_nxt;
    logic [IDX_W-1:0] w_total_nxt;
    logic             w_last_nxt;
    logic             w_err_nxt;

    logic [IDX_W-1:0] w_c_tab [NTAB];
    logic [IDX_W-1:0] w_c_k;
    logic [NP1-1:0]   w_first_ext;
    logic [N-1:0]     w_first;

    logic [NP1-1:0]   w_x;
    logic [NP1-1:0]   w_low;
    logic [NP1-1:0]   w_rip;
    logic [NP1-1:0]   w_diff;
    logic [NP1-1:0]   w_mask;
    logic [CW-1:0]    w_pc;
    logic [CW-1:0]    w_sh;
    logic [N-1:0]     w_succ;

    // C(N,k) lookup; entries beyond N are zero and never selected
    for (genvar g = 0; g < NTAB; g++) begin : g_ctab
        assign w_c_tab[g] = IDX_W'(f_binom(N, g));
    end

    assign w_c_k       = w_c_tab[bus.req_weight];
    assign w_first_ext = (NP1'(1) << bus.req_weight) - NP1'(1);
    assign w_first     = N'(w_first_ext);

    // Next word with same popcount: carry the lowest run up, refill ones at the bottom
    always_comb begin
        w_x    = NP1'(r_word);
        w_low  = w_x & (~w_x + NP1'(1));
        w_rip  = w_x + w_low;
        w_diff = w_x ^ w_rip;
        w_pc   = '0;
        for (int i = 0; i < NP1; i++) w_pc = w_pc + CW'(w_diff[i]);
        w_sh   = (w_pc >= CW'(2)) ? (w_pc - CW'(2)) : '0;
        w_mask = (NP1'(1) << w_sh) - NP1'(1);
        w_succ = N'(w_rip | w_mask);
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_index_nxt = r_index;
        w_total_nxt = r_total;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_weight > N_W) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMIT;
                        w_word_nxt  = w_first;
                        w_index_nxt = '0;
                        w_total_nxt = w_c_k;
                        w_last_nxt  = (w_c_k == IDX_W'(1));
                    end
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_word_nxt  = w_succ;
                        w_index_nxt = r_index + IDX_W'(1);
                        w_last_nxt  = ((r_index + IDX_W'(2)) == r_total);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_index     <= '0;
            r_total     <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word      <= w_word_nxt;
            r_index     <= w_index_nxt;
            r_total     <= w_total_nxt;
            r_last      <= w_last_nxt;
            r_err       <= w_err_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt == ST_EMIT);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.out_valid = r_busy;
    assign bus.busy      = r_busy;
    assign bus.out_word  = r_word;
    assign bus.out_last  = r_last;
    assign bus.out_index = r_index;
    assign bus.out_total = r_total;
    assign bus.err       = r_err;
endmodule
